// File: rtl/regfile_param.sv
// Parametrised register file (DEPTH x DATA_W, NUM_RD combinational read ports) with a hardware clear sweep.
// Optional macro REGFILE_BYPASS_EN forwards the WB write data to matching read ports in the same cycle.
module regfile_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_req,
  input  logic                       regWrite,
  input  logic [ADDR_W-1:0]          writeReg,
  input  logic [DATA_W-1:0]          writeData,
  input  logic [NUM_RD*ADDR_W-1:0]   readReg,
  output logic [NUM_RD*DATA_W-1:0]   readData,
  output logic                       busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Array has no reset; mem_we is already gated by rst_n so a held reset leaves it untouched.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    unique case (state_q)
      CLEAR: begin
        if (clr_req) begin
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
          if (&clr_idx_q) state_d = READY;
        end
      end
      READY: begin
        if (clr_req) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_idx_d = '0;
      end
    endcase
  end

  always_comb begin
    busy      = !rst_n || (state_q == CLEAR);
    mem_we    = 1'b0;
    mem_waddr = writeReg;
    mem_wdata = writeData;
    if (rst_n) begin
      if (state_q == CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx_q;
        mem_wdata = '0;
      end else if (!clr_req && regWrite && (writeReg != '0)) begin
        mem_we = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;

    assign raddr = readReg[g*ADDR_W +: ADDR_W];

    always_comb begin
      rdata = '0;
      if (!busy && (raddr != '0)) begin
        rdata = mem_q[raddr];
`ifdef REGFILE_BYPASS_EN
        if (regWrite && (writeReg != '0) && (writeReg == raddr)) rdata = writeData;
`endif
      end
    end

    assign readData[g*DATA_W +: DATA_W] = rdata;
  end

endmodule
